// File: rtl/aes_pkg.sv
// Shared AES types plus the InvSubBytes state enum and lane count.
// Lane count follows AES_INV_SUB_WIDE_EN (16 lanes when defined, 4 otherwise).
package aes_pkg;

  typedef logic [7:0] aes_8;
  typedef aes_8 [0:15] aes_128;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } aes_inv_sb_state_e;

`ifdef AES_INV_SUB_WIDE_EN
  localparam int AES_INV_SB_LANES = 16;
`else
  localparam int AES_INV_SB_LANES = 4;
`endif

endpackage

// File: rtl/aes_inv_sub_byte.sv
// Single-byte FIPS-197 inverse S-box, purely combinational table lookup.
module aes_inv_sub_byte
  import aes_pkg::*;
(
  input  aes_8 J,
  output aes_8 Z
);

  // Entry 0 sits in the most significant byte, so INV_SBOX[x] is InvSbox(x).
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign Z = INV_SBOX[J];

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// InvSubBytes over a 16-byte state with valid/ready handshakes on both sides.
// AES_INV_SUB_WIDE_EN selects 16 lanes (one BUSY cycle) instead of 4 lanes (four BUSY cycles).
module aes_inv_sub_bytes
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  aes_128            in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output aes_128            out_data,
  output aes_inv_sb_state_e dbg_state
);

  // Handshake: a transfer occurs on a rising edge where valid and ready are both
  // high; in_ready is high only in IDLE, out_valid only in DONE, so the two sides
  // never complete in the same cycle and out_data is frozen while out_valid waits.

  aes_inv_sb_state_e state, state_next;
  logic [1:0]        cnt;
  aes_128            work;
  aes_8              lane_in  [AES_INV_SB_LANES];
  aes_8              lane_out [AES_INV_SB_LANES];

  for (genvar l = 0; l < AES_INV_SB_LANES; l++) begin : g_lane
`ifdef AES_INV_SUB_WIDE_EN
    assign lane_in[l] = work[l];
`else
    // Lane l handles byte 4*cnt+l of the work register.
    assign lane_in[l] = work[{cnt, 2'(l)}];
`endif
    aes_inv_sub_byte u_sbox (
      .J(lane_in[l]),
      .Z(lane_out[l])
    );
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = BUSY;
`ifdef AES_INV_SUB_WIDE_EN
      BUSY: state_next = DONE;
`else
      BUSY: if (cnt == 2'd3) state_next = DONE;
`endif
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_data;
            cnt  <= '0;
          end
        end
        BUSY: begin
`ifdef AES_INV_SUB_WIDE_EN
          for (int l = 0; l < AES_INV_SB_LANES; l++) work[l] <= lane_out[l];
`else
          for (int l = 0; l < AES_INV_SB_LANES; l++) work[{cnt, 2'(l)}] <= lane_out[l];
`endif
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = work;
  assign dbg_state = state;

endmodule
